// File: rtl/uart_ctrl_param_if.sv
// rtl/uart_ctrl_param_if.sv - bus/serial-side signal bundle for uart_ctrl_param
interface uart_ctrl_param_if #(
    parameter int DATA_BITS = 8,
    parameter int DIV_W     = 11
);
    logic [DIV_W-1:0]     baud_divisor;
    logic [1:0]           parity_mode;
    logic                 stop2;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_wr_en;
    logic                 tx_full;
    logic                 tx_busy;
    logic                 tx;
    logic                 rx;
    logic                 rx_rd_en;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_empty;
    logic                 rx_parity_err;
    logic                 rx_frame_err;
    logic                 rx_overrun;
    logic                 err_clr;

    modport master (
        output baud_divisor, parity_mode, stop2, tx_data, tx_wr_en, rx, rx_rd_en, err_clr,
        input  tx_full, tx_busy, tx, rx_data, rx_empty, rx_parity_err, rx_frame_err, rx_overrun
    );

    modport slave (
        input  baud_divisor, parity_mode, stop2, tx_data, tx_wr_en, rx, rx_rd_en, err_clr,
        output tx_full, tx_busy, tx, rx_data, rx_empty, rx_parity_err, rx_frame_err, rx_overrun
    );
endinterface

// File: rtl/uart_ctrl_param.sv
// rtl/uart_ctrl_param.sv - parametrised full-duplex UART with FWFT FIFOs
module uart_ctrl_param_fifo #(
    parameter int W  = 8,
    parameter int AW = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;
    logic          push_ok, pop_ok;

    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign full    = count[AW];
    assign empty   = (count == '0);
    assign rdata   = empty ? '0 : mem[rptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop_ok)  rptr <= rptr + 1'b1;
            count <= count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr] <= wdata;
    end
endmodule

module uart_ctrl_param #(
    parameter int DATA_BITS = 8,
    parameter int FIFO_AW   = 4,
    parameter int DIV_W     = 11
) (
    input  logic              clk,
    input  logic              reset,
    uart_ctrl_param_if.slave  bus
);
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

    // Divisor is latched at each wrap so a mid-count change never stretches a tick period.
    logic [DIV_W-1:0] baud_cnt, div_q;
    logic             tick;
    assign tick = (baud_cnt == div_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            baud_cnt <= '0;
            div_q    <= '0;
        end else if (tick) begin
            baud_cnt <= '0;
            div_q    <= bus.baud_divisor;
        end else begin
            baud_cnt <= baud_cnt + 1'b1;
        end
    end

    logic [DATA_BITS-1:0] tx_head, rx_head;
    logic                 tx_empty, tx_fifo_full, tx_pop;
    logic                 rx_push, rx_fifo_full, rx_fifo_empty;
    logic [DATA_BITS-1:0] rx_shreg;

    uart_ctrl_param_fifo #(.W(DATA_BITS), .AW(FIFO_AW)) u_tx_fifo (
        .clk(clk), .reset(reset), .push(bus.tx_wr_en), .pop(tx_pop),
        .wdata(bus.tx_data), .rdata(tx_head), .full(tx_fifo_full), .empty(tx_empty)
    );

    uart_ctrl_param_fifo #(.W(DATA_BITS), .AW(FIFO_AW)) u_rx_fifo (
        .clk(clk), .reset(reset), .push(rx_push), .pop(bus.rx_rd_en),
        .wdata(rx_shreg), .rdata(rx_head), .full(rx_fifo_full), .empty(rx_fifo_empty)
    );

    tx_state_t            tx_state;
    logic [4:0]           tx_tcnt;
    logic [2:0]           tx_bit;
    logic [DATA_BITS-1:0] tx_shreg;
    logic                 tx_line, tx_par_en, tx_par_bit, tx_stop2;

    // Frames only launch on a tick so every bit spans exactly 16 tick periods.
    assign tx_pop = tick && !tx_empty &&
                    (tx_state == TX_IDLE || (tx_state == TX_STOP && tx_tcnt == {tx_stop2, 4'hF}));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state   <= TX_IDLE;
            tx_tcnt    <= '0;
            tx_bit     <= '0;
            tx_shreg   <= '0;
            tx_line    <= 1'b1;
            tx_par_en  <= 1'b0;
            tx_par_bit <= 1'b0;
            tx_stop2   <= 1'b0;
        end else if (tick) begin
            if (tx_pop) begin
                tx_state   <= TX_START;
                tx_shreg   <= tx_head;
                tx_par_en  <= (bus.parity_mode == 2'b01) || (bus.parity_mode == 2'b10);
                tx_par_bit <= (^tx_head) ^ (bus.parity_mode == 2'b10);
                tx_stop2   <= bus.stop2;
                tx_line    <= 1'b0;
                tx_tcnt    <= '0;
            end else begin
                case (tx_state)
                    TX_START: begin
                        tx_tcnt <= tx_tcnt + 1'b1;
                        if (tx_tcnt[3:0] == 4'hF) begin
                            tx_state <= TX_DATA;
                            tx_tcnt  <= '0;
                            tx_bit   <= '0;
                            tx_line  <= tx_shreg[0];
                        end
                    end
                    TX_DATA: begin
                        tx_tcnt <= tx_tcnt + 1'b1;
                        if (tx_tcnt[3:0] == 4'hF) begin
                            tx_tcnt <= '0;
                            if (tx_bit == 3'(DATA_BITS - 1)) begin
                                tx_state <= tx_par_en ? TX_PARITY : TX_STOP;
                                tx_line  <= tx_par_en ? tx_par_bit : 1'b1;
                            end else begin
                                tx_bit   <= tx_bit + 1'b1;
                                tx_shreg <= tx_shreg >> 1;
                                tx_line  <= tx_shreg[1];
                            end
                        end
                    end
                    TX_PARITY: begin
                        tx_tcnt <= tx_tcnt + 1'b1;
                        if (tx_tcnt[3:0] == 4'hF) begin
                            tx_state <= TX_STOP;
                            tx_tcnt  <= '0;
                            tx_line  <= 1'b1;
                        end
                    end
                    TX_STOP: begin
                        tx_tcnt <= tx_tcnt + 1'b1;
                        if (tx_tcnt == {tx_stop2, 4'hF}) tx_state <= TX_IDLE;
                    end
                    default: tx_line <= 1'b1;
                endcase
            end
        end
    end

    rx_state_t  rx_state;
    logic       rx_meta, rx_s, rx_par_en, rx_odd;
    logic [3:0] rx_tcnt;
    logic [2:0] rx_bit;
    logic       rx_sample, rx_stop_sample, par_set, frame_set, overrun_set;
    logic       par_err, frame_err, overrun;

    assign rx_sample      = tick && (rx_tcnt == 4'hF);
    assign rx_stop_sample = (rx_state == RX_STOP) && rx_sample;
    assign rx_push        = rx_stop_sample && rx_s && !rx_fifo_full;
    assign frame_set      = rx_stop_sample && !rx_s;
    assign overrun_set    = rx_stop_sample && rx_s && rx_fifo_full;
    assign par_set        = (rx_state == RX_PARITY) && rx_sample && (rx_s != ((^rx_shreg) ^ rx_odd));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            rx_state  <= RX_IDLE;
            rx_tcnt   <= '0;
            rx_bit    <= '0;
            rx_shreg  <= '0;
            rx_par_en <= 1'b0;
            rx_odd    <= 1'b0;
            par_err   <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            rx_meta   <= bus.rx;
            rx_s      <= rx_meta;
            par_err   <= par_set     | (par_err   & ~bus.err_clr);
            frame_err <= frame_set   | (frame_err & ~bus.err_clr);
            overrun   <= overrun_set | (overrun   & ~bus.err_clr);
            case (rx_state)
                RX_IDLE: if (!rx_s) begin
                    rx_state  <= RX_START;
                    rx_tcnt   <= '0;
                    rx_par_en <= (bus.parity_mode == 2'b01) || (bus.parity_mode == 2'b10);
                    rx_odd    <= (bus.parity_mode == 2'b10);
                end
                RX_START: if (tick) begin
                    rx_tcnt <= rx_tcnt + 1'b1;
                    if (rx_tcnt == 4'd7) begin
                        rx_state <= rx_s ? RX_IDLE : RX_DATA;
                        rx_tcnt  <= '0;
                        rx_bit   <= '0;
                    end
                end
                RX_DATA: if (tick) begin
                    rx_tcnt <= rx_tcnt + 1'b1;
                    if (rx_tcnt == 4'hF) begin
                        rx_shreg <= {rx_s, rx_shreg[DATA_BITS-1:1]};
                        rx_bit   <= rx_bit + 1'b1;
                        if (rx_bit == 3'(DATA_BITS - 1))
                            rx_state <= rx_par_en ? RX_PARITY : RX_STOP;
                    end
                end
                RX_PARITY: if (tick) begin
                    rx_tcnt <= rx_tcnt + 1'b1;
                    if (rx_tcnt == 4'hF) rx_state <= RX_STOP;
                end
                RX_STOP: if (tick) begin
                    rx_tcnt <= rx_tcnt + 1'b1;
                    if (rx_tcnt == 4'hF) rx_state <= RX_IDLE;
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    assign bus.tx            = tx_line;
    assign bus.tx_full       = tx_fifo_full;
    assign bus.tx_busy       = (tx_state != TX_IDLE) || !tx_empty;
    assign bus.rx_data       = rx_head;
    assign bus.rx_empty      = rx_fifo_empty;
    assign bus.rx_parity_err = par_err;
    assign bus.rx_frame_err  = frame_err;
    assign bus.rx_overrun    = overrun;
endmodule

// File: tb/tb_uart_ctrl_param.sv
// tb/tb_uart_ctrl_param.sv - directed self-checking bench for uart_ctrl_param
module tb_uart_ctrl_param;
    logic clk = 1'b0;
    logic reset;
    logic loop_en;
    logic rx_drv;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    uart_ctrl_param_if #(.DATA_BITS(8), .DIV_W(11)) bus ();

    uart_ctrl_param #(.DATA_BITS(8), .FIFO_AW(2), .DIV_W(11)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    assign bus.rx = loop_en ? bus.tx : rx_drv;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        @(negedge clk);
        bus.tx_data  = d;
        bus.tx_wr_en = 1'b1;
        @(negedge clk);
        bus.tx_wr_en = 1'b0;
    endtask

    task automatic pop();
        @(negedge clk);
        bus.rx_rd_en = 1'b1;
        @(negedge clk);
        bus.rx_rd_en = 1'b0;
    endtask

    task automatic wait_tx_low(input string tag);
        int n = 0;
        while (bus.tx !== 1'b0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check(tag, bus.tx, 1'b0);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (bus.tx_busy !== 1'b0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check(tag, bus.tx_busy, 1'b0);
    endtask

    // Sample the middle of each 64-clock bit, starting at the first negedge with tx low.
    task automatic capture(input int nbits, output logic [11:0] bits, output int first_high);
        bits       = '0;
        first_high = -1;
        wait_tx_low("tx_start_seen");
        for (int n = 0; n <= 32 + 64 * (nbits - 1); n++) begin
            if (n > 0) @(negedge clk);
            if (bus.tx === 1'b1 && first_high < 0) first_high = n;
            if (n % 64 == 32) bits[n / 64] = bus.tx;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_en, input logic par_bit,
                              input logic stop_bit);
        rx_drv = 1'b0;
        repeat (64) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = d[i];
            repeat (64) @(negedge clk);
        end
        if (par_en) begin
            rx_drv = par_bit;
            repeat (64) @(negedge clk);
        end
        rx_drv = stop_bit;
        repeat (stop_bit ? 64 : 48) @(negedge clk);
        rx_drv = 1'b1;
        repeat (64) @(negedge clk);
    endtask

    logic [11:0] bits;
    int          fh;
    int          cnt;
    logic [7:0]  lb_vec [4];

    initial begin
        reset            = 1'b0;
        loop_en          = 1'b0;
        rx_drv           = 1'b1;
        bus.baud_divisor = 11'd3;
        bus.parity_mode  = 2'b00;
        bus.stop2        = 1'b0;
        bus.tx_data      = '0;
        bus.tx_wr_en     = 1'b0;
        bus.rx_rd_en     = 1'b0;
        bus.err_clr      = 1'b0;
        lb_vec[0] = 8'h00; lb_vec[1] = 8'hFF; lb_vec[2] = 8'h5A; lb_vec[3] = 8'h81;
        repeat (3) @(negedge clk);

        check("rst_tx", bus.tx, 1'b1);
        check("rst_tx_full", bus.tx_full, 1'b0);
        check("rst_tx_busy", bus.tx_busy, 1'b0);
        check("rst_rx_empty", bus.rx_empty, 1'b1);
        check("rst_rx_data", bus.rx_data, 8'h00);
        check("rst_flags", {bus.rx_parity_err, bus.rx_frame_err, bus.rx_overrun}, 3'b000);
        reset = 1'b1;

        // Reset asserted mid-frame while tx is driving a 0 data bit (0x3C bit 1).
        push(8'h3C);
        wait_tx_low("rst_frame_start");
        repeat (32 + 64 * 2) @(negedge clk);
        check("pre_rst_tx_low", bus.tx, 1'b0);
        #2 reset = 1'b0;
        #1;
        check("midrst_tx", bus.tx, 1'b1);
        check("midrst_busy", bus.tx_busy, 1'b0);
        check("midrst_rx_empty", bus.rx_empty, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (bus.tx !== 1'b1) cnt++;
        end
        check("postrst_no_frame", cnt, 0);

        // 8N1, 64 clocks per bit.
        push(8'hA5);
        capture(10, bits, fh);
        check("a5_8n1_bits", bits, 12'h34A);
        check("a5_start_len", fh, 64);
        repeat (31) @(negedge clk);
        check("a5_busy_last", bus.tx_busy, 1'b1);
        @(negedge clk);
        check("a5_busy_end", bus.tx_busy, 1'b0);
        check("a5_tx_idle", bus.tx, 1'b1);

        bus.parity_mode = 2'b01;
        push(8'hA5);
        capture(11, bits, fh);
        check("a5_even_bits", bits, 12'h54A);
        wait_idle("even_idle");

        bus.parity_mode = 2'b10;
        push(8'hA5);
        capture(11, bits, fh);
        check("a5_odd_bits", bits, 12'h74A);
        wait_idle("odd_idle");

        // Two stop bits between queued frames: 128 high clocks, 96 after mid-stop.
        bus.parity_mode = 2'b00;
        bus.stop2       = 1'b1;
        push(8'h11);
        push(8'h22);
        capture(10, bits, fh);
        check("stop2_f1_bits", bits, 12'h222);
        cnt = 0;
        while (bus.tx !== 1'b0 && cnt < 400) begin
            @(negedge clk);
            cnt++;
        end
        check("stop2_gap", cnt, 96);
        capture(10, bits, fh);
        check("stop2_f2_bits", bits, 12'h244);
        wait_idle("stop2_idle");
        bus.stop2 = 1'b0;

        // Loopback with even parity.
        loop_en         = 1'b1;
        bus.parity_mode = 2'b01;
        for (int i = 0; i < 4; i++) push(lb_vec[i]);
        wait_idle("lb_idle");
        repeat (20) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("lb_nonempty_%0d", i), bus.rx_empty, 1'b0);
            check($sformatf("lb_data_%0d", i), bus.rx_data, lb_vec[i]);
            pop();
        end
        check("lb_empty", bus.rx_empty, 1'b1);
        check("lb_flags", {bus.rx_parity_err, bus.rx_frame_err, bus.rx_overrun}, 3'b000);
        loop_en = 1'b0;

        // Framing error then parity error on manually driven frames.
        bus.parity_mode = 2'b00;
        send_frame(8'h42, 1'b0, 1'b0, 1'b0);
        check("ferr_flag", bus.rx_frame_err, 1'b1);
        check("ferr_empty", bus.rx_empty, 1'b1);
        check("ferr_no_perr", bus.rx_parity_err, 1'b0);
        bus.parity_mode = 2'b01;
        send_frame(8'h42, 1'b1, 1'b1, 1'b1);
        check("perr_flag", bus.rx_parity_err, 1'b1);
        check("perr_pushed", bus.rx_empty, 1'b0);
        check("perr_data", bus.rx_data, 8'h42);
        check("perr_ferr_sticky", bus.rx_frame_err, 1'b1);
        @(negedge clk);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        check("clr_flags", {bus.rx_parity_err, bus.rx_frame_err, bus.rx_overrun}, 3'b000);
        pop();
        check("perr_popped", bus.rx_empty, 1'b1);

        // Overrun on a 4-deep RX FIFO.
        bus.parity_mode = 2'b00;
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b1);
        check("ovr_not_yet", bus.rx_overrun, 1'b0);
        send_frame(8'h05, 1'b0, 1'b0, 1'b1);
        check("ovr_flag", bus.rx_overrun, 1'b1);
        check("ovr_no_ferr", bus.rx_frame_err, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("ovr_data_%0d", i), bus.rx_data, 32'(i));
            pop();
        end
        check("ovr_drained", bus.rx_empty, 1'b1);
        @(negedge clk);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;

        // Short low glitch must not start a frame.
        rx_drv = 1'b0;
        repeat (20) @(negedge clk);
        rx_drv = 1'b1;
        repeat (200) @(negedge clk);
        check("glitch_empty", bus.rx_empty, 1'b1);
        check("glitch_flags", {bus.rx_parity_err, bus.rx_frame_err, bus.rx_overrun}, 3'b000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_ctrl_param.md
Name: uart_ctrl_param

Overview:
Parametrised full-duplex UART controller; successor to the fixed 8N1 UART top. Configurable data width, FIFO depth and baud divisor width; run-time parity (none/even/odd) and 1/2 stop bits; receive error detection (parity, framing, overrun). Contains a 16x-oversampling baud tick generator, TX and RX frame FSMs and two first-word-fall-through FIFOs. Sits between the bus-side GPIO/register logic and the serial pins.

Parameters:
DATA_BITS, 8, data bits per frame, legal 5..8
FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW per direction
DIV_W, 11, width of baud_divisor

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
baud_divisor  input  DIV_W  tick every baud_divisor+1 clocks; tick = 1/16 bit time
parity_mode  input  2  00 none, 01 even, 10 odd, 11 none
stop2  input  1  1 = two stop bits on TX
tx_data  input  DATA_BITS  TX FIFO write data
tx_wr_en  input  1  TX FIFO push
tx_full  output  1  TX FIFO full
tx_busy  output  1  TX FSM not IDLE or TX FIFO not empty
tx  output  1  serial out, idle high
rx  input  1  serial in, asynchronous
rx_rd_en  input  1  RX FIFO pop
rx_data  output  DATA_BITS  RX FIFO head (FWFT)
rx_empty  output  1  RX FIFO empty
rx_parity_err  output  1  sticky
rx_frame_err  output  1  sticky
rx_overrun  output  1  sticky
err_clr  input  1  clears all three sticky flags

Behaviour:
- Reset (reset=0, async): tx=1, tx_full=0, tx_busy=0, rx_empty=1, rx_data=0, all error flags 0, FIFOs emptied, both FSMs IDLE, baud counter 0, rx synchronizer flops = 1. A frame in flight is abandoned; tx rises to 1 immediately on reset assertion.
- Baud: counter counts 0..baud_divisor, tick is a one-clock pulse on the clock where counter==baud_divisor; counter then returns to 0. baud_divisor=0 gives tick every clock. Divisor changes take effect on the next wrap.
- FIFOs: depth 2**FIFO_AW, occupancy counter FIFO_AW+1 bits. Push when full is ignored (even if a pop occurs in the same cycle). Pop when empty is ignored. Simultaneous push+pop when neither full nor empty: occupancy unchanged, both happen. Pointers wrap modulo depth. rx_data shows head whenever rx_empty=0; updates the clock after a pop.
- TX FSM: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE. In IDLE with TX FIFO non-empty: pop head into shift register, latch parity_mode and stop2, go START. Each bit lasts 16 ticks. START drives 0; DATA drives LSB first, DATA_BITS bits; PARITY (skipped when mode none) drives XOR of data bits (even) or its inverse (odd); STOP drives 1 for 16 ticks, or 32 if latched stop2. Back-to-back frames: next START begins the clock after STOP ends if FIFO non-empty.
- RX: rx passes a 2-flop synchronizer. IDLE: synced rx=0 -> START, latch parity_mode, clear tick count. START: at tick 7 re-sample; 0 -> DATA, 1 -> IDLE (glitch rejected). DATA: sample every 16 ticks (mid-bit), LSB first, DATA_BITS samples. PARITY (if enabled): sample after 16 ticks; mismatch sets rx_parity_err. STOP: sample after 16 ticks; only one stop bit checked on RX.
- At STOP sample: if stop=0 set rx_frame_err, data discarded. Else if RX FIFO full set rx_overrun, data discarded. Else push data (parity-error frames are still pushed). FSM returns to IDLE on the same clock.
- err_clr clears flags; a set event in the same cycle wins (flag stays 1).
- Configuration inputs change safely mid-frame; new values apply from the next frame.

Test Plan:
- Reset mid-frame: push 0x3C, release, assert reset at bit 3 -> tx=1 same cycle, tx_busy=0, rx_empty=1, no further frame after release.
- TX 8N1, baud_divisor=3 (64 clk/bit): push 0xA5 -> tx: 0 for 64 clk, then 1,0,1,0,0,1,0,1, then 1; frame 640 clk, tx_busy falls after.
- Parity/stop: parity_mode=01 push 0xA5 -> parity bit 0; parity_mode=10 -> 1; stop2=1 -> stop high 128 clk before next start of queued byte.
- Loopback tx->rx, even parity, push 0x00,0xFF,0x5A,0x81 -> rx_data sequence identical, no error flags.
- RX errors: drive frame 0x42 with stop=0 -> rx_frame_err=1, rx_empty stays 1; even parity with wrong parity bit -> rx_parity_err=1, 0x42 pushed; err_clr -> flags 0.
- Overrun/glitch: FIFO_AW=2, send 5 frames without rx_rd_en -> first 4 stored, rx_overrun=1; rx low 20 clk (<7 ticks) -> no start, no push.
